// File: rtl/counter_driver_pkg.sv
// Shared types for the counter driver: command opcodes, FSM states, default width.
package counter_driver_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_INC   = 2'b10,
        OP_CHECK = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INC,
        S_SETTLE,
        S_RESP
    } state_e;

endpackage

// File: rtl/counter_driver.sv
// Drives an external counter from a command stream, tracks the value it should hold
// and reports the sampled counter value with a mismatch flag.
module counter_driver
    import counter_driver_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] ctr_data_in,
    output logic             ctr_ld,
    output logic             ctr_inc,
    input  logic [WIDTH-1:0] ctr_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_q,
    output logic             rsp_err
);

    state_e           state;
    state_e           state_nxt;
    op_e              op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] model_q;
    logic             accept;
    logic             settle_err;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op_e'(cmd_op))
                        OP_LOAD: state_nxt = S_LOAD;
                        OP_INC:  state_nxt = (cmd_data != '0) ? S_INC : S_SETTLE;
                        default: state_nxt = S_SETTLE;
                    endcase
                end
            end
            S_LOAD:   state_nxt = S_SETTLE;
            S_INC:    if (rem_q == WIDTH'(1)) state_nxt = S_SETTLE;
            S_SETTLE: state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        ctr_ld      = 1'b0;
        ctr_inc     = 1'b0;
        ctr_data_in = '0;
        rsp_valid   = 1'b0;
        case (state)
            S_IDLE: cmd_ready = rst;
            S_LOAD: begin
                ctr_ld      = 1'b1;
                ctr_data_in = data_q;
            end
            S_INC:  ctr_inc   = 1'b1;
            S_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // CHECK compares against the operand; LOAD/INC against the tracked model value.
    always_comb begin
        settle_err = 1'b0;
        case (op_q)
            OP_LOAD, OP_INC: settle_err = (ctr_q != model_q);
            OP_CHECK:        settle_err = (ctr_q != data_q);
            default:         settle_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q    <= OP_NOP;
            data_q  <= '0;
            rem_q   <= '0;
            model_q <= '0;
            rsp_q   <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= op_e'(cmd_op);
                        data_q <= cmd_data;
                        rem_q  <= cmd_data;
                    end
                end
                S_LOAD: model_q <= data_q;
                S_INC: begin
                    model_q <= model_q + WIDTH'(1);
                    rem_q   <= rem_q - WIDTH'(1);
                end
                S_SETTLE: begin
                    rsp_q   <= ctr_q;
                    rsp_err <= settle_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/counter_driver.md
COUNTER_DRIVER -- requirements
Module: counter_driver

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the counter data width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 The module SHALL have port cmd_ready, output, 1 bit: a command is accepted on the edge where cmd_valid and cmd_ready are both high.
REQ-006 The module SHALL have port cmd_op, input, 2 bits: the command opcode, with 00 NOP, 01 LOAD, 10 INC, 11 CHECK.
REQ-007 The module SHALL have port cmd_data, input, WIDTH bits: the load value for LOAD, the repeat count for INC, the expected value for CHECK.
REQ-008 The module SHALL have port ctr_data_in, output, WIDTH bits: the load value driven to the counter.
REQ-009 The module SHALL have port ctr_ld, output, 1 bit: the counter load strobe.
REQ-010 The module SHALL have port ctr_inc, output, 1 bit: the counter increment strobe.
REQ-011 The module SHALL have port ctr_q, input, WIDTH bits: the registered counter value, which updates on the edge after ld/inc.
REQ-012 The module SHALL have port rsp_valid, output, 1 bit: a response is held.
REQ-013 The module SHALL have port rsp_ready, input, 1 bit: the response is consumed on the edge where rsp_valid and rsp_ready are both high.
REQ-014 The module SHALL have port rsp_q, output, WIDTH bits: the sampled ctr_q value.
REQ-015 The module SHALL have port rsp_err, output, 1 bit: the sampled ctr_q value differs from the expected value.

Function
REQ-016 The module SHALL implement an FSM with states IDLE, LOAD, INC, SETTLE and RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-017 On acceptance, the module SHALL capture cmd_op and cmd_data and go to LOAD (op 01), INC (op 10, count != 0) or SETTLE (op 00, op 11, or INC with count 0).
REQ-018 LOAD SHALL last exactly 1 cycle, with ctr_ld=1 and ctr_data_in=captured data; the model register SHALL take the captured data; next state SHALL be SETTLE.
REQ-019 INC SHALL assert ctr_inc for exactly N consecutive cycles, where N is the captured count (1..2^WIDTH-1); the model SHALL add 1 per pulse modulo 2^WIDTH; next state SHALL be SETTLE.
REQ-020 ctr_ld and ctr_inc SHALL never be high in the same cycle; both SHALL be 0 outside LOAD and INC respectively.
REQ-021 ctr_data_in SHALL be 0 outside LOAD.
REQ-022 SETTLE SHALL last 1 cycle; at its end, rsp_q SHALL take ctr_q.
REQ-023 At the end of SETTLE, rsp_err SHALL take: (ctr_q != model) for LOAD/INC; (ctr_q != captured data) for CHECK; 0 for NOP.
REQ-024 CHECK and NOP SHALL NOT change the model register.
REQ-025 RESP SHALL hold rsp_valid=1 with rsp_q and rsp_err stable until rsp_ready=1, then return to IDLE.
REQ-026 rsp_valid SHALL be low in every state other than RESP.
REQ-027 Latency from the acceptance edge to rsp_valid SHALL be: LOAD 3 cycles; INC N+2 cycles; CHECK/NOP/INC(0) 2 cycles.
REQ-028 A new command SHALL be accepted no earlier than the cycle after the response handshake; there SHALL be no command overlap.
REQ-029 The model SHALL wrap from 2^WIDTH-1 to 0 with no error flag; a counter that wraps identically SHALL yield rsp_err=0.

Reset
REQ-030 While rst=0 at a clock edge, the module SHALL set state=IDLE and model=0; ctr_ld, ctr_inc, ctr_data_in, rsp_valid, rsp_q and rsp_err SHALL all be 0.
REQ-031 cmd_ready SHALL be 0 while rst=0.
REQ-032 Reset mid-command (in LOAD, INC, SETTLE or RESP) SHALL abort the command and drop any pending response; strobes SHALL be low from the edge after the reset edge.

Structure
REQ-033 Package counter_driver_pkg SHALL hold the opcode enum (OP_NOP, OP_LOAD, OP_INC, OP_CHECK), the state enum, and the default WIDTH constant.
REQ-034 The design SHALL be a single module with no sub-module; the repeat counter and model register SHALL be local registers.

Verification
REQ-035 Bench scenario: LOAD 0x5A -> ctr_ld high for 1 cycle with ctr_data_in=0x5A; rsp_q=0x5A, rsp_err=0, rsp_valid 3 cycles after acceptance.
REQ-036 Bench scenario: LOAD 0xFE then INC 3 -> exactly 3 ctr_inc pulses; rsp_q=0x01, rsp_err=0 (wrap).
REQ-037 Bench scenario: INC 0 -> no ctr_inc pulse; rsp_q equals the current count, rsp_err=0, latency 2 cycles.
REQ-038 Bench scenario: CHECK 0x10 with ctr_q=0x11 -> rsp_q=0x11, rsp_err=1, model unchanged.
REQ-039 Bench scenario: rsp_ready held low 5 cycles -> rsp_valid, rsp_q and rsp_err stable throughout, cmd_ready=0 throughout.
REQ-040 Bench scenario: rst=0 during INC 20 after 7 pulses -> ctr_inc low from the next edge, no response, IDLE with cmd_ready=1 after rst returns to 1.
